// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RV32I core.
// Sequences one instruction at a time through FETCH, DECODE and the execute and
// writeback states. Outputs are Moore-decoded from the state register. The only
// input-dependent gating is mem_ready in FETCH and zero in BEQ.
//
// Optional feature: define MC_CTRL_UTYPE_EN to decode LUI/AUIPC into the UTYPE
// state. Without it, both opcodes are illegal and their immsrc is I-type (000).
//
// Ports:
//   clk        - clock, rising edge active
//   rst_n      - asynchronous active-low reset
//   op         - instr[6:0]
//   funct3     - instr[14:12], only qualifies BEQ
//   zero       - ALU zero flag
//   mem_ready  - memory completes the current access this cycle
//   pcwrite    - PC enable
//   adrsrc     - memory address select (0 PC, 1 ALUOut)
//   memwrite   - memory write strobe
//   irwrite    - IR / old-PC enable
//   regwrite   - register file write enable
//   resultsrc  - result select (00 ALUOut, 01 Data, 10 ALUResult)
//   alusrca    - ALU A select (00 PC, 01 OldPC, 10 rs1, 11 zero)
//   alusrcb    - ALU B select (00 rs2, 01 ImmExt, 10 const 4)
//   aluop      - ALU decoder op (00 add, 01 sub, 10 funct-decoded)
//   immsrc     - immediate format (I 000, S 001, B 010, J 011, U 100)
//   illegal    - sticky illegal-opcode flag
//   state      - current state, for debug
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [2:0] immsrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StUtype    = 4'd11,
    StIllegal  = 4'd12
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  state_e state_q, state_d;
  state_e decode_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Opcode dispatch out of DECODE.
  always_comb begin
    decode_next = StIllegal;
    case (op)
      OpLoad, OpStore: decode_next = StMemAdr;
      OpRType:         decode_next = StExecR;
      OpIType:         decode_next = StExecI;
      OpBranch:        decode_next = (funct3 == 3'b000) ? StBeq : StIllegal;
      OpJal:           decode_next = StJal;
`ifdef MC_CTRL_UTYPE_EN
      OpLui, OpAuipc:  decode_next = StUtype;
`endif
      default:         decode_next = StIllegal;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode:   state_d = decode_next;
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StUtype:    state_d = StAluWb;
      StIllegal:  state_d = StIllegal;
      default:    state_d = StFetch;
    endcase
  end

  // Outputs decode from the registered state, so they are glitch-free apart
  // from the mem_ready and zero gating, which must act within the same cycle.
  always_comb begin
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    illegal   = 1'b0;
    unique case (state_q)
      StFetch: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
      end
      StDecode: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      StMemAdr: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      StMemRead: begin
        adrsrc = 1'b1;
      end
      StMemWb: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      StMemWrite: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      StExecR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      StExecI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      StAluWb: begin
        regwrite = 1'b1;
      end
      StBeq: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        pcwrite = zero;
      end
      StJal: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MC_CTRL_UTYPE_EN
      StUtype: begin
        alusrcb = 2'b01;
        alusrca = (op == OpLui) ? 2'b11 : 2'b01;
      end
`endif
      StIllegal: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
    // FETCH enables follow mem_ready, so reset must mask them explicitly.
    if (!rst_n) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  // Immediate format follows op in every state.
  always_comb begin
    immsrc = 3'b000;
    case (op)
      OpLoad, OpIType: immsrc = 3'b000;
      OpStore:         immsrc = 3'b001;
      OpBranch:        immsrc = 3'b010;
      OpJal:           immsrc = 3'b011;
`ifdef MC_CTRL_UTYPE_EN
      OpLui, OpAuipc:  immsrc = 3'b100;
`endif
      default:         immsrc = 3'b000;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each instruction pushes its expected
// per-cycle outputs (built from the state table) into a queue together with the
// mem_ready value to drive; drain() replays the queue against the DUT.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic [2:0] immsrc;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [20:0] v;
    logic        mr;
  } item_t;
  item_t exp_q[$];

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct3    (funct3),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pcwrite   (pcwrite),
    .adrsrc    (adrsrc),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .resultsrc (resultsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .immsrc    (immsrc),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_model(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
`ifdef MC_CTRL_UTYPE_EN
      7'b0110111, 7'b0010111: return 3'b100;
`endif
      default:    return 3'b000;
    endcase
  endfunction

  // {state, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
  //  alusrca, alusrcb, aluop, immsrc, illegal}
  function automatic logic [20:0] model(input logic [3:0] st, input logic mr, input logic z,
                                        input logic [6:0] o);
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, a, b, aop;
    {pcw, adr, mw, irw, rw, ill} = 6'b0;
    {rs, a, b, aop} = 8'b0;
    case (st)
      4'd0:  begin b = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin adr = 1'b1; mw = 1'b1; end
      4'd6:  begin a = 2'b10; aop = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      4'd8:  rw = 1'b1;
      4'd9:  begin a = 2'b10; aop = 2'b01; pcw = z; end
      4'd10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      4'd11: begin b = 2'b01; a = (o == 7'b0110111) ? 2'b11 : 2'b01; end
      4'd12: ill = 1'b1;
      default: ;
    endcase
    return {st, pcw, adr, mw, irw, rw, rs, a, b, aop, imm_model(o), ill};
  endfunction

  function automatic logic [20:0] observed();
    return {state, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
            alusrca, alusrcb, aluop, immsrc, illegal};
  endfunction

  task automatic check(input string tag, input logic [20:0] exp_v);
    logic [20:0] obs;
    obs = observed();
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: state=%0d outs=%h, expected state=%0d outs=%h",
             tag, obs[20:17], obs[16:0], exp_v[20:17], exp_v[16:0]);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic mr);
    item_t it;
    it.v  = model(st, mr, zero, op);
    it.mr = mr;
    exp_q.push_back(it);
  endtask

  // Entered just after a rising edge; each item covers one clock cycle.
  task automatic drain(input string tag);
    item_t it;
    int    n = 0;
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      mem_ready = it.mr;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, n), it.v);
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset between edges, checks the asynchronous effect, then releases.
  task automatic reset_pulse(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check(tag, model(4'd0, 1'b0, 1'b0, op));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    check("reset", model(4'd0, 1'b0, 1'b0, op));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type
    op = 7'b0110011; funct3 = 3'b101;
    push(0, 1); push(1, 1); push(6, 1); push(8, 1);
    drain("rtype");

    // LW with two stall cycles in MEMREAD
    op = 7'b0000011; funct3 = 3'b010;
    push(0, 1); push(1, 1); push(2, 1); push(3, 0); push(3, 0); push(3, 1); push(4, 1);
    drain("lw_stall");

    // SW with one stall cycle in MEMWRITE
    op = 7'b0100011;
    push(0, 1); push(1, 0); push(2, 0); push(5, 0); push(5, 1);
    drain("sw_stall");

    // I-ALU with one FETCH stall
    op = 7'b0010011; funct3 = 3'b000;
    push(0, 0); push(0, 1); push(1, 1); push(7, 1); push(8, 1);
    drain("iop_fetch_stall");

    // BEQ taken then not taken
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    push(0, 1); push(1, 1); push(9, 1);
    drain("beq_taken");
    zero = 1'b0;
    push(0, 1); push(1, 1); push(9, 1);
    drain("beq_not_taken");

    // JAL
    op = 7'b1101111; funct3 = 3'b011;
    push(0, 1); push(1, 1); push(10, 1); push(8, 1);
    drain("jal");

`ifdef MC_CTRL_UTYPE_EN
    op = 7'b0110111;
    push(0, 1); push(1, 1); push(11, 1); push(8, 1);
    drain("lui");
    op = 7'b0010111;
    push(0, 1); push(1, 1); push(11, 1); push(8, 1);
    drain("auipc");
`else
    op = 7'b0110111;
    push(0, 1); push(1, 1); push(12, 0); push(12, 1);
    drain("lui_illegal");
    reset_pulse("lui_illegal_reset");
`endif

    // Reset during a stalled store: no write may follow
    op = 7'b0100011; funct3 = 3'b010;
    push(0, 1); push(1, 1); push(2, 1); push(5, 0);
    drain("sw_pre_reset");
    reset_pulse("sw_mid_reset");
    op = 7'b0110011;
    push(0, 1); push(1, 1); push(6, 1); push(8, 1);
    drain("rtype_after_reset");

    // BNE is not supported and must trap
    op = 7'b1100011; funct3 = 3'b001; zero = 1'b1;
    push(0, 1); push(1, 1); push(12, 1);
    drain("bne_illegal");
    reset_pulse("bne_reset");

    // Unknown opcode, sticky illegal, asynchronous reset out of it
    op = 7'b1111111; funct3 = 3'b000; zero = 1'b0;
    push(0, 1); push(1, 1); push(12, 0); push(12, 1); push(12, 1);
    drain("illegal_op");
    reset_pulse("illegal_async_reset");

    op = 7'b0010011;
    push(0, 1); push(1, 1); push(7, 1); push(8, 1); push(0, 0);
    drain("iop_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
